div_issue: RTL and testbench

Divide issue/commit controller between the EX stage and the iterative `div` unit. It accepts a DIV/DIVU from EX, latches the operands, and drives the divider's start/annul handshake. It stalls the pipeline until the quotient and remainder are committed into the architectural HI/LO registers, which it owns. It also applies MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

---
 rtl/div_issue.sv | 126 ++++++++++++
 tb/tb_div_issue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue.sv
// Divide issue/commit controller: hands a DIV/DIVU from EX to the iterative
// divider, stalls EX until the result lands in HI/LO, and owns HI/LO.
module div_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    input  logic        hi_we_i,
    input  logic [31:0] hi_wdata_i,
    input  logic        lo_we_i,
    input  logic [31:0] lo_wdata_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic        signed_q, signed_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        commit;

    assign accept = (state_q == IDLE) && ex_div_i && !flush_i;
    // A flush in BUSY wins over a simultaneous ready: the result is discarded.
    assign commit = (state_q == BUSY) && !flush_i && div_ready_i;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (div_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, start handshake and HI/LO write path
    always_comb begin
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        if (accept) begin
            signed_d = ex_signed_i;
            op1_d    = ex_op1_i;
            op2_d    = ex_op2_i;
        end

        // Start stays high through BUSY until ready or flush, low in DONE/IDLE.
        start_d = accept || ((state_q == BUSY) && !flush_i && !div_ready_i);

        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = div_result_i[63:32];
            lo_d = div_result_i[31:0];
        end else begin
            if (hi_we_i) hi_d = hi_wdata_i;
            if (lo_we_i) lo_d = lo_wdata_i;
        end
    end

    // Output logic
    always_comb begin
        stall_o     = accept || ((state_q == BUSY) && !flush_i);
        div_annul_o = (state_q == BUSY) && flush_i;
        div_done_o  = (state_q == DONE);
    end

    assign div_start_o  = start_q;
    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a behavioural iterative-divider model.
module tb_div_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_i, ex_signed_i, flush_i;
    logic [31:0] ex_op1_i, ex_op2_i;
    logic        stall_o, div_start_o, div_signed_o, div_annul_o, div_done_o;
    logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        hi_we_i, lo_we_i;
    logic [31:0] hi_wdata_i, lo_wdata_i;

    int tests_run = 0;
    int tests_failed = 0;

    // Divider model: ready rises lat edges after start is first seen.
    int          lat = 5;
    int          m_cnt;
    logic        m_ready;
    logic [63:0] m_res;
    logic        use_model;
    logic        man_ready;
    logic [63:0] man_res;

    always #5 clk = ~clk;

    div_issue dut (
        .clk(clk), .rst(rst),
        .ex_div_i(ex_div_i), .ex_signed_i(ex_signed_i),
        .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i),
        .flush_i(flush_i), .stall_o(stall_o),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_annul_o(div_annul_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .hi_we_i(hi_we_i), .hi_wdata_i(hi_wdata_i),
        .lo_we_i(lo_we_i), .lo_wdata_i(lo_wdata_i),
        .hi_o(hi_o), .lo_o(lo_o), .div_done_o(div_done_o)
    );

    function automatic logic [63:0] div_calc(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = a; sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= 0;
            m_ready <= 1'b0;
            m_res   <= '0;
        end else if (!div_start_o || div_annul_o) begin
            m_cnt   <= 0;
            m_ready <= 1'b0;
        end else if (!m_ready) begin
            if (m_cnt == lat - 1) begin
                m_ready <= 1'b1;
                m_res   <= div_calc(div_signed_o, div_op1_o, div_op2_o);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    assign div_ready_i  = use_model ? m_ready : man_ready;
    assign div_result_i = use_model ? m_res : man_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Issue one divide at the next negedge and wait for the DONE cycle.
    // Returns with the bench positioned in the DONE cycle.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int stalls);
        int  n;
        bit  got;
        @(negedge clk);
        ex_div_i = 1'b1; ex_signed_i = sgn; ex_op1_i = a; ex_op2_i = b;
        #1;
        check("acc_start_low", div_start_o, 1'b0);
        check("acc_stall", stall_o, 1'b1);
        stalls = 1;
        @(negedge clk);
        ex_div_i = 1'b0; ex_op1_i = '0; ex_op2_i = '0;
        #1;
        check("busy_start", div_start_o, 1'b1);
        got = 1'b0;
        n = 0;
        while (!got && n < 60) begin
            if (div_done_o) begin
                got = 1'b1;
            end else begin
                if (stall_o) stalls++;
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("done_seen", got, 1'b1);
        check("done_stall", stall_o, 1'b0);
        check("done_start", div_start_o, 1'b0);
    endtask

    initial begin
        int st;
        rst = 1'b1;
        ex_div_i = 0; ex_signed_i = 0; ex_op1_i = 0; ex_op2_i = 0; flush_i = 0;
        hi_we_i = 0; lo_we_i = 0; hi_wdata_i = 0; lo_wdata_i = 0;
        use_model = 1'b1; man_ready = 1'b0; man_res = '0;
        #1;
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        check("rst_start", div_start_o, 1'b0);
        check("rst_done", div_done_o, 1'b0);
        check("rst_op1", div_op1_o, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // DIVU 100/7, ready latency 5
        run_div(1'b0, 32'd100, 32'd7, st);
        check("divu100_stall_cycles", st, 7);
        check("divu100_hi", hi_o, 32'd2);
        check("divu100_lo", lo_o, 32'd14);
        @(negedge clk); #1;
        check("divu100_done_once", div_done_o, 1'b0);
        check("divu100_start_idle", div_start_o, 1'b0);

        // Signed divides
        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, st);
        check("div_m7_2_lo", lo_o, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi_o, 32'hFFFF_FFFF);
        run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, st);
        check("div_7_m2_lo", lo_o, 32'hFFFF_FFFD);
        check("div_7_m2_hi", hi_o, 32'h0000_0001);

        // Divide by zero
        run_div(1'b0, 32'h1234, 32'd0, st);
        check("div0_hi", hi_o, 32'd0);
        check("div0_lo", lo_o, 32'd0);

        // Preload HI/LO, then flush two cycles into BUSY
        @(negedge clk);
        hi_we_i = 1; hi_wdata_i = 32'hAAAA_0000; lo_we_i = 1; lo_wdata_i = 32'h5555;
        @(negedge clk);
        hi_we_i = 0; lo_we_i = 0;
        ex_div_i = 1; ex_signed_i = 0; ex_op1_i = 32'd40; ex_op2_i = 32'd5;
        @(negedge clk);
        ex_div_i = 0;
        @(negedge clk);
        flush_i = 1;
        #1;
        check("flush_annul", div_annul_o, 1'b1);
        check("flush_stall", stall_o, 1'b0);
        @(negedge clk);
        flush_i = 0;
        #1;
        check("flush_start_low", div_start_o, 1'b0);
        check("flush_no_done", div_done_o, 1'b0);
        check("flush_annul_idle", div_annul_o, 1'b0);
        check("flush_hi", hi_o, 32'hAAAA_0000);
        check("flush_lo", lo_o, 32'h5555);
        run_div(1'b0, 32'd9, 32'd3, st);
        check("divu9_3_lo", lo_o, 32'd3);
        check("divu9_3_hi", hi_o, 32'd0);

        // Flush coinciding with ready: no write
        use_model = 1'b0;
        @(negedge clk);
        ex_div_i = 1; ex_op1_i = 32'd1; ex_op2_i = 32'd1;
        @(negedge clk);
        ex_div_i = 0;
        man_ready = 1; man_res = {32'h77, 32'h88}; flush_i = 1;
        #1;
        check("flushrdy_annul", div_annul_o, 1'b1);
        @(negedge clk);
        man_ready = 0; flush_i = 0;
        #1;
        check("flushrdy_hi", hi_o, 32'd0);
        check("flushrdy_lo", lo_o, 32'd3);
        check("flushrdy_no_done", div_done_o, 1'b0);

        // MTLO during BUSY, MTHI colliding with commit
        @(negedge clk);
        ex_div_i = 1; ex_op1_i = 32'd1; ex_op2_i = 32'd1;
        @(negedge clk);
        ex_div_i = 0;
        lo_we_i = 1; lo_wdata_i = 32'h22;
        @(negedge clk);
        lo_we_i = 0;
        #1;
        check("mtlo_busy_lo", lo_o, 32'h22);
        check("mtlo_busy_stall", stall_o, 1'b1);
        @(negedge clk);
        man_ready = 1; man_res = {32'h5, 32'h9};
        hi_we_i = 1; hi_wdata_i = 32'h1111_1111;
        @(negedge clk);
        man_ready = 0; hi_we_i = 0;
        #1;
        check("mthi_commit_hi", hi_o, 32'h5);
        check("mthi_commit_lo", lo_o, 32'h9);
        check("mthi_commit_done", div_done_o, 1'b1);
        use_model = 1'b1;

        // Back-to-back DIVUs, accepted in the IDLE cycle right after DONE
        lat = 3;
        run_div(1'b0, 32'd20, 32'd3, st);
        check("b2b1_hi", hi_o, 32'd2);
        check("b2b1_lo", lo_o, 32'd6);
        run_div(1'b0, 32'd50, 32'd6, st);
        check("b2b2_hi", hi_o, 32'd2);
        check("b2b2_lo", lo_o, 32'd8);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        ex_div_i = 1; ex_op1_i = 32'd77; ex_op2_i = 32'd7;
        @(negedge clk);
        ex_div_i = 0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_start", div_start_o, 1'b0);
        check("arst_stall", stall_o, 1'b0);
        check("arst_hi", hi_o, 32'd0);
        check("arst_lo", lo_o, 32'd0);
        check("arst_op1", div_op1_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
